imc_instr_sequencer: RTL and testbench



---
 rtl/imc_instr_sequencer.sv | 139 +++++++++++++
 tb/tb_imc_instr_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imc_instr_sequencer.sv
// Instruction sequencer: fetches words from the instruction buffer, decodes them
// and issues WRITE/READ/COMPUTE commands to the in-memory-compute array controller.
module imc_instr_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  abort,
  input  logic                  buf_empty,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [3:0]            cmd_op,
  output logic [7:0]            cmd_row,
  output logic [7:0]            cmd_col,
  output logic [11:0]           cmd_imm,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [CNT_WIDTH-1:0]  instr_count
);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_WRITE   = 4'd1;
  localparam logic [3:0] OP_READ    = 4'd2;
  localparam logic [3:0] OP_COMPUTE = 4'd3;
  localparam logic [3:0] OP_HALT    = 4'd15;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_DONE
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic                    cmd_valid_q;
  logic [3:0]              cmd_op_q;
  logic [7:0]              cmd_row_q;
  logic [7:0]              cmd_col_q;
  logic [11:0]             cmd_imm_q;
  logic                    done_q;
  logic                    illegal_q;
  logic [CNT_WIDTH-1:0]    count_q;

  // Sequencer FSM; abort overrides every state and keeps pc/illegal/count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_imm_q   <= '0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        cmd_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              pc_q      <= start_addr;
              illegal_q <= 1'b0;
              count_q   <= '0;
              state_q   <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (!buf_empty) state_q <= S_WAIT;
          end
          S_WAIT: begin
            instr_q <= buf_data;
            pc_q    <= pc_q + ADDR_WIDTH'(1);
            state_q <= S_DECODE;
          end
          S_DECODE: begin
            case (instr_q[31:28])
              OP_NOP: state_q <= S_FETCH;
              OP_WRITE, OP_READ, OP_COMPUTE: begin
                cmd_op_q    <= instr_q[31:28];
                cmd_row_q   <= instr_q[27:20];
                cmd_col_q   <= instr_q[19:12];
                cmd_imm_q   <= instr_q[11:0];
                cmd_valid_q <= 1'b1;
                state_q     <= S_ISSUE;
              end
              OP_HALT: begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              default: begin
                illegal_q <= 1'b1;
                state_q   <= S_FETCH;
              end
            endcase
          end
          S_ISSUE: begin
            if (cmd_ready) begin
              cmd_valid_q <= 1'b0;
              if (count_q != CNT_MAX) count_q <= count_q + CNT_WIDTH'(1);
              state_q <= S_FETCH;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Read strobe follows buf_empty in the same cycle so an empty buffer is never popped
  assign buf_rd_en   = (state_q == S_FETCH) && !buf_empty;
  assign buf_rd_addr = pc_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign cmd_row     = cmd_row_q;
  assign cmd_col     = cmd_col_q;
  assign cmd_imm     = cmd_imm_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign pc_out      = pc_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_imc_instr_sequencer.sv
// Randomized bench for imc_instr_sequencer: programs in a 16-word buffer model are
// walked by a program-level reference and compared with the issued command stream.
module tb_imc_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  start_addr;
  logic        abort;
  logic        buf_empty;
  logic        buf_rd_en;
  logic [3:0]  buf_rd_addr;
  logic [31:0] buf_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_row;
  logic [7:0]  cmd_col;
  logic [11:0] cmd_imm;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [3:0]  pc_out;
  logic [7:0]  instr_count;

  imc_instr_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .abort(abort),
    .buf_empty(buf_empty), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_data(buf_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_imm(cmd_imm),
    .busy(busy), .done(done), .illegal(illegal), .pc_out(pc_out),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          hs_total = 0;
  logic [31:0] exp_cmds[$];
  int          exp_addrs[$];
  int          got_addrs[$];
  int          hs_cycles[$];
  int          exp_pc, exp_cnt, exp_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Buffer read port: registered data, valid the cycle after the strobe
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_data <= '0;
    else if (buf_rd_en) buf_data <= mem[buf_rd_addr];
  end

  // Observe handshakes, reads and done pulses mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (buf_rd_en) begin
        check("rd_while_empty", 32'(buf_empty), 32'd0);
        got_addrs.push_back(int'(buf_rd_addr));
      end
      if (cmd_valid && cmd_ready) begin
        hs_total++;
        hs_cycles.push_back(cyc);
        if (exp_cmds.size() == 0) check("cmd_extra", 32'(exp_cmds.size()), 32'd1);
        else check("cmd", {cmd_op, cmd_row, cmd_col, cmd_imm}, exp_cmds.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  // Program-level reference: walk words from sa until HALT
  task automatic model_run(input int sa);
    int a, n;
    logic [31:0] w;
    a = sa; n = 0; exp_ill = 0;
    exp_cmds.delete(); exp_addrs.delete();
    for (int s = 0; s < 16; s++) begin
      w = mem[a];
      exp_addrs.push_back(a);
      a = (a + 1) % 16;
      if (w[31:28] == 4'hF) break;
      else if (w[31:28] >= 4'd1 && w[31:28] <= 4'd3) begin
        exp_cmds.push_back(w);
        n++;
      end else if (w[31:28] != 4'd0) exp_ill = 1;
    end
    exp_pc  = a;
    exp_cnt = (n > 255) ? 255 : n;
  endtask

  task automatic gen_prog();
    int ops [8] = '{0, 1, 2, 3, 1, 3, 5, 12};
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = $urandom();
      mem[i] = {4'(ops[$urandom_range(0, 7)]), w[27:0]};
    end
    w = $urandom();
    mem[$urandom_range(0, 15)] = {4'hF, w[27:0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int sa);
    got_addrs.delete();
    hs_cycles.delete();
    start_addr = 4'(sa);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_run(input int d0, input bit rnd);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin
      if (rnd) begin
        cmd_ready = 1'($urandom_range(0, 1));
        buf_empty = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 7) == 0);
        start_addr = 4'($urandom_range(0, 15));
      end
      step();
      t++;
    end
    start = 1'b0; cmd_ready = 1'b1; buf_empty = 1'b0;
    check("done_pulse", 32'(done_cnt - d0), 32'd1);
    check("instr_count", 32'(instr_count), 32'(exp_cnt));
    check("pc_out", 32'(pc_out), 32'(exp_pc));
    check("illegal", 32'(illegal), 32'(exp_ill));
    check("busy_after_done", 32'(busy), 32'd0);
    check("cmds_left", 32'(exp_cmds.size()), 32'd0);
    check("rd_addr_count", 32'(got_addrs.size()), 32'(exp_addrs.size()));
    for (int i = 0; i < got_addrs.size() && i < exp_addrs.size(); i++)
      check("rd_addr", 32'(got_addrs[i]), 32'(exp_addrs[i]));
    repeat (2) step();
    check("done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic run_prog(input int sa, input bit rnd);
    int d0;
    model_run(sa);
    d0 = done_cnt;
    start_run(sa);
    finish_run(d0, rnd);
  endtask

  initial begin
    int d0, h0, t;
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; abort = 1'b0;
    buf_empty = 1'b0; cmd_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (2) step();
    check("rst_status", 32'({busy, done, illegal, cmd_valid, buf_rd_en, pc_out, instr_count}), 32'd0);
    check("rst_cmd", {cmd_op, cmd_row, cmd_col, cmd_imm}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Basic program
    mem[0] = 32'h1050_30AA; mem[1] = 32'h3050_0000; mem[2] = 32'hF000_0000;
    run_prog(0, 1'b0);

    // Backpressure on a WRITE
    mem[0] = 32'h1123_4567; mem[1] = 32'hF000_0000;
    model_run(0);
    d0 = done_cnt;
    cmd_ready = 1'b0;
    start_run(0);
    t = 0;
    while (!cmd_valid && t < 20) begin step(); t++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(cmd_valid), 32'd1);
      check("bp_fields", {cmd_op, cmd_row, cmd_col, cmd_imm}, 32'h1123_4567);
      check("bp_count", 32'(instr_count), 32'd0);
      step();
    end
    cmd_ready = 1'b1;
    step();
    check("bp_count_after", 32'(instr_count), 32'd1);
    check("bp_valid_after", 32'(cmd_valid), 32'd0);
    finish_run(d0, 1'b0);

    // Empty stall in FETCH
    gen_prog();
    model_run(5);
    d0 = done_cnt;
    buf_empty = 1'b1;
    start_run(5);
    for (int i = 0; i < 10; i++) begin
      check("stall_rd_en", 32'(buf_rd_en), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      step();
    end
    buf_empty = 1'b0;
    #1 check("stall_release_rd_en", 32'(buf_rd_en), 32'd1);
    finish_run(d0, 1'b0);

    // Wrap and illegal
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000;
    mem[14] = 32'h7000_0000; mem[15] = 32'h0; mem[0] = 32'hF000_0000;
    run_prog(14, 1'b0);

    // Abort during ISSUE, then abort beating start
    mem[9] = 32'h1AB1_2345; mem[10] = 32'h2CD6_7890; mem[11] = 32'hF000_0000;
    exp_cmds.delete();
    exp_cmds.push_back(32'h1AB1_2345);
    d0 = done_cnt; h0 = hs_total;
    cmd_ready = 1'b1;
    start_run(9);
    t = 0;
    while (hs_total == h0 && t < 30) begin step(); t++; end
    cmd_ready = 1'b0;
    check("abort_first_hs", 32'(hs_total - h0), 32'd1);
    t = 0;
    while (!cmd_valid && t < 30) begin step(); t++; end
    check("abort_in_issue", 32'(cmd_valid), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(cmd_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(instr_count), 32'd1);
    abort = 1'b1; start = 1'b1; start_addr = 4'd2;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_over_start", 32'(busy), 32'd0);
    check("abort_pc_kept", 32'(pc_out), 32'd11);
    repeat (4) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_count_kept", 32'(instr_count), 32'd1);
    cmd_ready = 1'b1;
    gen_prog();
    run_prog(3, 1'b0);

    // Randomized programs with random backpressure, empties and ignored starts
    for (int r = 0; r < 20; r++) begin
      gen_prog();
      run_prog($urandom_range(0, 15), 1'b1);
    end

    // Endless WRITE loop: throughput and counter saturation, stopped by abort
    for (int i = 0; i < 16; i++) begin
      w = $urandom();
      mem[i] = {4'h1, w[27:0]};
    end
    exp_cmds.delete();
    for (int i = 0; i < 320; i++) exp_cmds.push_back(mem[i % 16]);
    d0 = done_cnt;
    start_run(0);
    repeat (1100) step();
    check("sat_hs_enough", 32'(hs_cycles.size() >= 12), 32'd1);
    for (int i = 0; i < 10 && i + 1 < hs_cycles.size(); i++)
      check("throughput", 32'(hs_cycles[i+1] - hs_cycles[i]), 32'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("sat_count", 32'(instr_count), 32'd255);
    check("sat_busy", 32'(busy), 32'd0);
    check("sat_no_done", 32'(done_cnt - d0), 32'd0);
    exp_cmds.delete();

    // Async reset mid-WAIT
    gen_prog();
    mem[6] = 32'h1111_1111;
    start_run(6);
    check("pre_rst_rd_en", 32'(buf_rd_en), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_status", 32'({busy, done, illegal, cmd_valid, buf_rd_en, pc_out, instr_count}), 32'd0);
    check("async_rst_cmd", {cmd_op, cmd_row, cmd_col, cmd_imm}, 32'd0);
    exp_cmds.delete();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_idle", 32'({busy, buf_rd_en}), 32'd0);
    end
    gen_prog();
    run_prog(7, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
